// File: rtl/pattern_gen_multi.sv
// pattern_gen_multi: plays a BRAM-resident bit pattern onto NUM_GPIO outputs.
// Each RAM word is split into RAM_WIDTH/NUM_GPIO slices, LSB slice first, and
// each slice is held for a programmable period. The next word is fetched during
// the last slice of the current one, so samples are back to back across words
// and across passes.
// Optional feature macro: PAT_GEN_TRIG_START_EN (armed start on a trigger_in edge).
module pattern_gen_multi #(
  parameter int unsigned RAM_ADDR_BITS = 8,
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned NUM_GPIO      = 8
) (
  input  logic                     clk_100mhz,
  input  logic                     rst_n_sync,
  input  logic                     cfg_enable,
  input  logic [RAM_ADDR_BITS-1:0] cfg_end_address,
  input  logic [2:0]               cfg_timestep_sel,
  input  logic [4:0]               cfg_stage1_count,
  input  logic [7:0]               cfg_repeat_count,
  input  logic                     cfg_trig_start,
  input  logic                     trigger_in,
  input  logic [RAM_WIDTH-1:0]     ram_data,
  output logic                     ram_read_enable,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [NUM_GPIO-1:0]      gpio_out,
  output logic                     pattern_active,
  output logic                     pattern_armed,
  output logic                     pattern_done,
  output logic [7:0]               loop_count
);

  localparam int unsigned SLICES = RAM_WIDTH / NUM_GPIO;
  localparam int unsigned SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int unsigned PW     = 13;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_PREFETCH, S_RUN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic                     en_q;
  logic [RAM_ADDR_BITS-1:0] end_q;
  logic [2:0]               tsel_q;
  logic [4:0]               stage1_q;
  logic [7:0]               repeat_q;
  logic [RAM_WIDTH-1:0]     shreg_q;
  logic [SW-1:0]            sidx_q, sidx_d;
  logic [PW-1:0]            pcnt_q, pcnt_d;
  logic                     pf_phase_q;
  logic                     end_word_q;

  logic          en_rise, trig_rise;
  logic [PW-1:0] per_raw, per;
  logic          last_cyc, last_slice, pass_end, pass_cont;
  logic [7:0]    loop_inc, loop_d, loop_after;
  logic          pf_enter, rd_slot, rd_need;

  assign en_rise = cfg_enable & ~en_q;

  // Sample period in cycles, never shorter than two.
  assign per_raw = (PW'(stage1_q) + PW'(1)) << tsel_q;
  assign per     = (per_raw < PW'(2)) ? PW'(2) : per_raw;

  assign last_cyc   = (pcnt_q == per - PW'(1));
  assign last_slice = (sidx_q == SW'(SLICES - 1));
  assign pass_end   = (state_q == S_RUN) && last_cyc && last_slice && end_word_q && cfg_enable;

  // Completed-pass count as it will be after this edge, saturating at 255.
  assign loop_inc   = (loop_count == 8'hFF) ? 8'hFF : loop_count + 8'd1;
  assign loop_d     = ((state_q == S_IDLE) && en_rise) ? 8'd0 : (pass_end ? loop_inc : loop_count);
  assign loop_after = (loop_d == 8'hFF) ? 8'hFF : loop_d + 8'd1;
  assign pass_cont  = (repeat_q == 8'd0) || (loop_d < repeat_q);

  // Fetch slot: the cycle two before the end of the last slice of a word.
  assign pf_enter = (state_d == S_PREFETCH) && (state_q != S_PREFETCH);
  assign rd_slot  = (state_d == S_RUN) && (sidx_d == SW'(SLICES - 1)) && (pcnt_d == per - PW'(2));
  assign rd_need  = (ram_addr != end_q) || (repeat_q == 8'd0) || (loop_after < repeat_q);

`ifdef PAT_GEN_TRIG_START_EN
  logic trig_q;
  assign trig_rise = trigger_in & ~trig_q;

  // Trigger edge history and armed indication.
  always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      trig_q        <= 1'b0;
      pattern_armed <= 1'b0;
    end else begin
      trig_q        <= trigger_in;
      pattern_armed <= (state_d == S_ARMED);
    end
  end
`else
  logic unused_trig;
  assign trig_rise     = 1'b0;
  assign unused_trig   = ^{cfg_trig_start, trigger_in, trig_rise};
  assign pattern_armed = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
    if (!rst_n_sync) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic; a low cfg_enable overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en_rise) begin
`ifdef PAT_GEN_TRIG_START_EN
          state_d = cfg_trig_start ? S_ARMED : S_PREFETCH;
`else
          state_d = S_PREFETCH;
`endif
        end
      end
      S_ARMED:    if (trig_rise) state_d = S_PREFETCH;
      S_PREFETCH: if (pf_phase_q) state_d = S_RUN;
      S_RUN:      if (pass_end && !pass_cont) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (!cfg_enable) state_d = S_IDLE;
  end

  // Period and slice counters for the next cycle.
  always_comb begin
    pcnt_d = pcnt_q;
    sidx_d = sidx_q;
    if (state_q == S_PREFETCH) begin
      pcnt_d = '0;
      sidx_d = '0;
    end else if (state_q == S_RUN) begin
      if (last_cyc) begin
        pcnt_d = '0;
        sidx_d = last_slice ? '0 : sidx_q + SW'(1);
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  // Config latch, counters, BRAM reads, sample shifting and status outputs.
  always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      en_q            <= 1'b0;
      end_q           <= '0;
      tsel_q          <= '0;
      stage1_q        <= '0;
      repeat_q        <= '0;
      shreg_q         <= '0;
      sidx_q          <= '0;
      pcnt_q          <= '0;
      pf_phase_q      <= 1'b0;
      end_word_q      <= 1'b0;
      ram_read_enable <= 1'b0;
      ram_addr        <= '0;
      gpio_out        <= '0;
      pattern_active  <= 1'b0;
      pattern_done    <= 1'b0;
      loop_count      <= 8'd0;
    end else begin
      en_q <= cfg_enable;
      if ((state_q == S_IDLE) && en_rise) begin
        end_q    <= cfg_end_address;
        tsel_q   <= cfg_timestep_sel;
        stage1_q <= cfg_stage1_count;
        repeat_q <= cfg_repeat_count;
      end
      loop_count <= loop_d;
      pcnt_q     <= pcnt_d;
      sidx_q     <= sidx_d;
      pf_phase_q <= (state_q == S_PREFETCH) && (state_d == S_PREFETCH);
      if (rd_slot) end_word_q <= (ram_addr == end_q);

      ram_read_enable <= 1'b0;
      if (pf_enter) begin
        ram_read_enable <= 1'b1;
        ram_addr        <= '0;
      end else if (rd_slot && rd_need) begin
        ram_read_enable <= 1'b1;
        ram_addr        <= (ram_addr == end_q) ? '0 : ram_addr + RAM_ADDR_BITS'(1);
      end

      if (state_d != S_RUN) begin
        gpio_out <= '0;
      end else if ((state_q == S_PREFETCH) || (last_cyc && last_slice)) begin
        gpio_out <= ram_data[NUM_GPIO-1:0];
        shreg_q  <= RAM_WIDTH'(ram_data >> NUM_GPIO);
      end else if ((state_q == S_RUN) && last_cyc) begin
        gpio_out <= shreg_q[NUM_GPIO-1:0];
        shreg_q  <= RAM_WIDTH'(shreg_q >> NUM_GPIO);
      end

      pattern_active <= (state_d == S_PREFETCH) || (state_d == S_RUN);
      pattern_done   <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Bench for pattern_gen_multi: two instances (8 outputs / 8-bit address and
// 2 outputs / 4-bit address), a vector table driving a cycle-accurate trace
// scoreboard, and directed sequences for abort, saturation, trigger and reset.
module tb_pattern_gen_multi;

  logic clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  logic       rst_n_sync;
  logic [2:0] cfg_timestep_sel;
  logic [4:0] cfg_stage1_count;
  logic [7:0] cfg_repeat_count;
  logic       cfg_trig_start, trigger_in;

  logic       en_a, ren_a, act_a, armed_a, done_a;
  logic [7:0] end_a, ram_data_a, addr_a, gpio_a, loop_a;
  logic       en_b, ren_b, act_b, armed_b, done_b;
  logic [3:0] end_b, addr_b;
  logic [7:0] ram_data_b, loop_b;
  logic [1:0] gpio_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [16];

  pattern_gen_multi u_dut_a (
    .clk_100mhz(clk_100mhz), .rst_n_sync(rst_n_sync), .cfg_enable(en_a),
    .cfg_end_address(end_a), .cfg_timestep_sel(cfg_timestep_sel),
    .cfg_stage1_count(cfg_stage1_count), .cfg_repeat_count(cfg_repeat_count),
    .cfg_trig_start(cfg_trig_start), .trigger_in(trigger_in), .ram_data(ram_data_a),
    .ram_read_enable(ren_a), .ram_addr(addr_a), .gpio_out(gpio_a),
    .pattern_active(act_a), .pattern_armed(armed_a), .pattern_done(done_a),
    .loop_count(loop_a));

  pattern_gen_multi #(.RAM_ADDR_BITS(4), .RAM_WIDTH(8), .NUM_GPIO(2)) u_dut_b (
    .clk_100mhz(clk_100mhz), .rst_n_sync(rst_n_sync), .cfg_enable(en_b),
    .cfg_end_address(end_b), .cfg_timestep_sel(cfg_timestep_sel),
    .cfg_stage1_count(cfg_stage1_count), .cfg_repeat_count(cfg_repeat_count),
    .cfg_trig_start(cfg_trig_start), .trigger_in(trigger_in), .ram_data(ram_data_b),
    .ram_read_enable(ren_b), .ram_addr(addr_b), .gpio_out(gpio_b),
    .pattern_active(act_b), .pattern_armed(armed_b), .pattern_done(done_b),
    .loop_count(loop_b));

  // Synchronous-read BRAM models.
  always @(posedge clk_100mhz) begin
    if (ren_a) ram_data_a <= mem_a[addr_a];
    if (ren_b) ram_data_b <= mem_b[addr_b];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  typedef struct packed {
    logic       act;
    logic       done;
    logic [7:0] gpio;
  } obs_t;

  obs_t       q_a[$], q_b[$];
  logic [7:0] rd_a[$], rd_b[$];
  bit         mon_a = 0, mon_b = 0;
  obs_t       ea, eb;

  // Scoreboard: per-cycle trace and BRAM read order for each instance.
  always @(negedge clk_100mhz) begin
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      check("trace_a", 32'({act_a, done_a, gpio_a}), 32'(ea));
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      check("trace_b", 32'({act_b, done_b, 8'(gpio_b)}), 32'(eb));
    end
    if (mon_a && ren_a) begin
      check("read_expected_a", 32'(rd_a.size() > 0), 32'd1);
      if (rd_a.size() > 0) check("read_addr_a", 32'(addr_a), 32'(rd_a.pop_front()));
    end
    if (mon_b && ren_b) begin
      check("read_expected_b", 32'(rd_b.size() > 0), 32'd1);
      if (rd_b.size() > 0) check("read_addr_b", 32'(addr_b), 32'(rd_b.pop_front()));
    end
  end

  typedef struct {
    bit sel;
    int end_addr;
    int st1;
    int tsel;
    int rep;
    int exp_loop;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic push_obs(input bit sel, input logic a, input logic d, input logic [7:0] g);
    obs_t o;
    o.act = a; o.done = d; o.gpio = g;
    if (sel) q_b.push_back(o); else q_a.push_back(o);
  endtask

  function automatic int pend(input bit sel);
    return sel ? q_b.size() : q_a.size();
  endfunction

  // Expected behaviour: idle, two prefetch cycles, every slice for P cycles, done, idle.
  task automatic build_expect(input vec_t v);
    int p, ng, ns;
    logic [7:0] word, mask;
    p = (v.st1 + 1) << v.tsel;
    if (p < 2) p = 2;
    ng = v.sel ? 2 : 8;
    ns = 8 / ng;
    mask = 8'((1 << ng) - 1);
    push_obs(v.sel, 1'b0, 1'b0, 8'h00);
    push_obs(v.sel, 1'b1, 1'b0, 8'h00);
    push_obs(v.sel, 1'b1, 1'b0, 8'h00);
    for (int pass = 0; pass < v.rep; pass++) begin
      for (int w = 0; w <= v.end_addr; w++) begin
        word = v.sel ? mem_b[w] : mem_a[w];
        if (v.sel) rd_b.push_back(8'(w)); else rd_a.push_back(8'(w));
        for (int sl = 0; sl < ns; sl++)
          for (int c = 0; c < p; c++)
            push_obs(v.sel, 1'b1, 1'b0, 8'(word >> (sl * ng)) & mask);
      end
    end
    push_obs(v.sel, 1'b0, 1'b1, 8'h00);
    push_obs(v.sel, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    tick();
    cfg_stage1_count = 5'(v.st1);
    cfg_timestep_sel = 3'(v.tsel);
    cfg_repeat_count = 8'(v.rep);
    cfg_trig_start   = 1'b0;
    if (v.sel) end_b = 4'(v.end_addr); else end_a = 8'(v.end_addr);
    build_expect(v);
    if (v.sel) begin mon_b = 1; en_b = 1'b1; end
    else       begin mon_a = 1; en_a = 1'b1; end
    tick();
    cfg_stage1_count = 5'($urandom);
    cfg_timestep_sel = 3'($urandom);
    cfg_repeat_count = 8'($urandom);
    end_a = 8'($urandom);
    end_b = 4'($urandom);
    n = 0;
    while (pend(v.sel) != 0 && n < 20000) begin tick(); n++; end
    check($sformatf("vec%0d_drained", idx), 32'(pend(v.sel)), 32'd0);
    repeat (3) tick();
    @(negedge clk_100mhz);
    check($sformatf("vec%0d_no_restart", idx), 32'(v.sel ? act_b : act_a), 32'd0);
    check($sformatf("vec%0d_loop_count", idx), 32'(v.sel ? loop_b : loop_a), 32'(v.exp_loop));
    check($sformatf("vec%0d_reads_left", idx), 32'(v.sel ? rd_b.size() : rd_a.size()), 32'd0);
    tick();
    en_a = 1'b0; en_b = 1'b0;
    tick();
    mon_a = 0; mon_b = 0;
    q_a.delete(); q_b.delete(); rd_a.delete(); rd_b.delete();
  endtask

  task automatic start_a(input int end_addr, input int st1, input int tsel, input int rep, input logic trig);
    end_a = 8'(end_addr);
    cfg_stage1_count = 5'(st1);
    cfg_timestep_sel = 3'(tsel);
    cfg_repeat_count = 8'(rep);
    cfg_trig_start = trig;
    en_a = 1'b1;
  endtask

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, act_cnt;
    vecs[0] = '{0, 2,   1, 0, 1, 1};
    vecs[1] = '{1, 0,   0, 2, 2, 2};
    vecs[2] = '{1, 15,  0, 0, 3, 3};
    vecs[3] = '{0, 0,   0, 1, 3, 3};
    vecs[4] = '{0, 5,   2, 1, 2, 2};
    vecs[5] = '{1, 3,   1, 0, 1, 1};
    vecs[6] = '{0, 255, 0, 0, 1, 1};

    mem_a[0] = 8'h11; mem_a[1] = 8'h22; mem_a[2] = 8'h33;
    for (int i = 3; i < 256; i++) mem_a[i] = 8'(i * 37 + 5);
    mem_b[0] = 8'hE4;
    for (int i = 1; i < 16; i++) mem_b[i] = 8'($urandom);

    rst_n_sync = 1'b0;
    en_a = 1'b0; en_b = 1'b0; end_a = '0; end_b = '0;
    cfg_timestep_sel = '0; cfg_stage1_count = '0; cfg_repeat_count = '0;
    cfg_trig_start = 1'b0; trigger_in = 1'b0;
    #12;
    check("rst_active_a", 32'(act_a), 0);
    check("rst_gpio_a", 32'(gpio_a), 0);
    check("rst_ren_a", 32'(ren_a), 0);
    check("rst_addr_a", 32'(addr_a), 0);
    check("rst_loop_a", 32'(loop_a), 0);
    check("rst_done_a", 32'(done_a), 0);
    check("rst_armed_a", 32'(armed_a), 0);
    check("rst_active_b", 32'(act_b), 0);
    check("rst_gpio_b", 32'(gpio_b), 0);
    tick();
    rst_n_sync = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort mid-pass with infinite repeat: idle next cycle, no done, count kept.
    tick();
    start_a(3, 0, 0, 0, 1'b0);
    repeat (14) tick();
    @(negedge clk_100mhz);
    check("abort_pre_active", 32'(act_a), 1);
    check("abort_pre_gpio", 32'(gpio_a), 32'h22);
    en_a = 1'b0;
    cnt = 0;
    tick();
    @(negedge clk_100mhz);
    check("abort_active", 32'(act_a), 0);
    check("abort_gpio", 32'(gpio_a), 0);
    check("abort_loop_kept", 32'(loop_a), 1);
    for (int i = 0; i < 10; i++) begin
      if (done_a) cnt++;
      tick();
      @(negedge clk_100mhz);
    end
    check("abort_no_done", 32'(cnt), 0);

    // Pass counter saturation, then clear on the next start.
    tick();
    start_a(0, 0, 0, 0, 1'b0);
    repeat (600) tick();
    check("sat_loop", 32'(loop_a), 255);
    check("sat_active", 32'(act_a), 1);
    en_a = 1'b0;
    tick();
    en_a = 1'b1;
    tick();
    check("restart_loop_clear", 32'(loop_a), 0);
    check("restart_active", 32'(act_a), 1);
    en_a = 1'b0;
    repeat (3) tick();

`ifdef PAT_GEN_TRIG_START_EN
    // Armed start: wait 50 cycles for a trigger edge, then prefetch.
    start_a(0, 0, 0, 1, 1'b1);
    cnt = 0; act_cnt = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i == 50) trigger_in = 1'b1;
      @(negedge clk_100mhz);
      if (armed_a) cnt++;
      if (ren_a || act_a || (gpio_a != 0)) act_cnt++;
    end
    tick();
    trigger_in = 1'b0;
    @(negedge clk_100mhz);
    check("trig_armed_cycles", 32'(cnt), 50);
    check("trig_quiet_before", 32'(act_cnt), 0);
    check("trig_read_after", 32'(ren_a), 1);
    check("trig_addr_after", 32'(addr_a), 0);
    check("trig_armed_after", 32'(armed_a), 0);
    cnt = 0;
    for (int i = 0; i < 20 && cnt == 0; i++) begin
      tick();
      @(negedge clk_100mhz);
      if (done_a) cnt++;
    end
    check("trig_done", 32'(cnt), 1);
    tick();
    en_a = 1'b0; cfg_trig_start = 1'b0;
    repeat (3) tick();
`else
    // Trigger start request is ignored: straight to prefetch.
    start_a(0, 0, 0, 1, 1'b1);
    tick();
    @(negedge clk_100mhz);
    check("notrig_armed", 32'(armed_a), 0);
    check("notrig_active", 32'(act_a), 1);
    check("notrig_read", 32'(ren_a), 1);
    tick();
    en_a = 1'b0; cfg_trig_start = 1'b0;
    repeat (3) tick();
`endif

    // Asynchronous reset during RUN, then quiet until a new enable edge.
    start_a(3, 0, 0, 0, 1'b0);
    repeat (13) tick();
    check("rstrun_pre_active", 32'(act_a), 1);
    check("rstrun_pre_loop", 32'(loop_a), 1);
    rst_n_sync = 1'b0;
    en_a = 1'b0;
    #1;
    check("rstrun_active", 32'(act_a), 0);
    check("rstrun_gpio", 32'(gpio_a), 0);
    check("rstrun_addr", 32'(addr_a), 0);
    check("rstrun_loop", 32'(loop_a), 0);
    check("rstrun_ren", 32'(ren_a), 0);
    tick();
    rst_n_sync = 1'b1;
    act_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_100mhz);
      if (act_a || ren_a || done_a || (gpio_a != 0)) act_cnt++;
      tick();
    end
    check("rstrun_quiet", 32'(act_cnt), 0);

    // Enable held high through reset starts right after release.
    rst_n_sync = 1'b0;
    en_a = 1'b1;
    tick();
    rst_n_sync = 1'b1;
    @(negedge clk_100mhz);
    check("rsthold_idle_first", 32'(act_a), 0);
    tick();
    @(negedge clk_100mhz);
    check("rsthold_active", 32'(act_a), 1);
    check("rsthold_read", 32'(ren_a), 1);
    tick();
    en_a = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
